// File: rtl/dcache_uncache_resp_pkg.sv
// rtl/dcache_uncache_resp_pkg.sv - shared state encoding and size helper for the uncached data responder
package dcache_uncache_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_WRITE = 3'd3,
    ST_B     = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Pipeline size codes (0=byte, 1=half, 2=word) map directly onto the bus size field.
  function automatic logic [2:0] bus_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/dcache_uncache_resp.sv
// rtl/dcache_uncache_resp.sv - single-outstanding uncached load/store responder bridging MEM to an AXI-style port
module dcache_uncache_resp
  import dcache_uncache_resp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic                cancel,
  output logic                data_addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [2:0]          ar_size,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_size,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  input  logic                b_valid,
  output logic                b_ready
);

  state_t state, state_n;

  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                drop_q;
  logic                aw_done_q;
  logic                w_done_q;

  always_comb begin
    state_n      = state;
    data_addr_ok = 1'b0;
    data_ok      = 1'b0;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    aw_valid     = 1'b0;
    w_valid      = 1'b0;
    b_ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        data_addr_ok = data_req & ~cancel;
        if (data_addr_ok) state_n = data_wr ? ST_WRITE : ST_AR;
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_n = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (r_valid) state_n = ST_RESP;
      end
      ST_WRITE: begin
        // Each channel drops its valid once its own beat is taken; leave only when both are in.
        aw_valid = ~aw_done_q;
        w_valid  = ~w_done_q;
        if ((aw_done_q | aw_ready) && (w_done_q | w_ready)) state_n = ST_B;
      end
      ST_B: begin
        b_ready = 1'b1;
        if (b_valid) state_n = ST_RESP;
      end
      ST_RESP: begin
        data_ok = ~drop_q & ~cancel;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      drop_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (data_addr_ok) begin
        size_q    <= data_size;
        addr_q    <= data_addr;
        wdata_q   <= data_wdata;
        wstrb_q   <= data_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_valid && aw_ready) aw_done_q <= 1'b1;
      if (w_valid && w_ready) w_done_q <= 1'b1;
      if (r_valid && r_ready) rdata_q <= r_data;
      // A flush only forgets the response; the bus transaction is always carried to completion.
      if (state == ST_RESP) drop_q <= 1'b0;
      else if (state != ST_IDLE && cancel) drop_q <= 1'b1;
    end
  end

  assign data_rdata = rdata_q;
  assign ar_addr    = addr_q;
  assign ar_size    = bus_size(size_q);
  assign aw_addr    = addr_q;
  assign aw_size    = bus_size(size_q);
  assign w_data     = wdata_q;
  assign w_strb     = wstrb_q;

endmodule

// File: tb/tb_dcache_uncache_resp.sv
// tb/tb_dcache_uncache_resp.sv - self-checking bench with a word-memory bus slave and request/response reference model
module tb_dcache_uncache_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_req = 1'b0, data_wr = 1'b0, cancel = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_ok;
  logic [31:0] data_rdata;
  logic        ar_valid, ar_ready = 1'b0, r_valid = 1'b0, r_ready;
  logic [31:0] ar_addr, r_data = '0, aw_addr, w_data;
  logic [2:0]  ar_size, aw_size;
  logic        aw_valid, aw_ready = 1'b0, w_valid, w_ready = 1'b0, b_valid = 1'b0, b_ready;
  logic [3:0]  w_strb;

  dcache_uncache_resp dut (
    .clk(clk), .reset(reset), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata), .cancel(cancel),
    .data_addr_ok(data_addr_ok), .data_ok(data_ok), .data_rdata(data_rdata),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave-side word memory and the bench's own expectation of its contents.
  logic [31:0] slv_mem [8];
  logic [31:0] ref_mem [8];
  logic [31:0] last_r = '0;
  logic [31:0] last_ar_addr = '0, last_aw_addr = '0;
  logic [2:0]  last_ar_size = '0, last_aw_size = '0;
  int          slave_done = 0;
  bit          abort = 0;
  int          d_ar = -1, d_r = -1, d_aw = -1, d_w = -1, d_b = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int fixed);
    return (fixed >= 0) ? fixed : int'($urandom_range(0, 3));
  endfunction

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n && !abort; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic slave_read();
    bit hs;
    wait_cycles(pick(d_ar));
    hs = 0;
    ar_ready = 1'b1;
    while (!hs && !abort) begin
      hs = ar_valid;
      if (hs) begin last_ar_addr = ar_addr; last_ar_size = ar_size; end
      @(posedge clk); #1;
    end
    ar_ready = 1'b0;
    if (abort) return;
    chk("r_ready_after_ar", r_ready, 1);
    wait_cycles(pick(d_r));
    hs = 0;
    r_valid = 1'b1;
    r_data  = slv_mem[last_ar_addr[4:2]];
    while (!hs && !abort) begin
      hs = r_ready;
      @(posedge clk);
      if (hs) begin slave_done++; last_r = r_data; end
      #1;
    end
    r_valid = 1'b0;
    r_data  = $urandom;
  endtask

  task automatic slave_write();
    bit aw_hs, w_hs, aw_seen;
    logic [31:0] wd;
    logic [3:0]  ws;
    aw_hs = 0; w_hs = 0; aw_seen = 0; wd = '0; ws = '0;
    fork
      begin
        wait_cycles(pick(d_aw));
        aw_ready = 1'b1;
        while (!aw_hs && !abort) begin
          aw_hs = aw_valid;
          if (aw_hs) begin last_aw_addr = aw_addr; last_aw_size = aw_size; end
          @(posedge clk);
          if (aw_hs) aw_seen = 1;
          #1;
        end
        aw_ready = 1'b0;
        if (aw_hs) chk("aw_drop_after_hs", aw_valid, 0);
      end
      begin
        wait_cycles(pick(d_w));
        w_ready = 1'b1;
        while (!w_hs && !abort) begin
          w_hs = w_valid;
          if (w_hs) begin wd = w_data; ws = w_strb; end
          @(posedge clk); #1;
        end
        w_ready = 1'b0;
        if (w_hs) begin
          chk("w_drop_after_hs", w_valid, 0);
          chk("b_ready_after_w", b_ready, aw_seen);
        end
      end
    join
    if (abort) return;
    for (int b = 0; b < 4; b++)
      if (ws[b]) slv_mem[last_aw_addr[4:2]][8*b +: 8] = wd[8*b +: 8];
    wait_cycles(pick(d_b));
    b_valid = 1'b1;
    w_hs = 0;
    while (!w_hs && !abort) begin
      w_hs = b_ready;
      @(posedge clk);
      if (w_hs) slave_done++;
      #1;
    end
    b_valid = 1'b0;
  endtask

  initial begin : slave
    forever begin
      @(posedge clk); #1;
      if (!abort) begin
        if (ar_valid) slave_read();
        else if (aw_valid || w_valid) slave_write();
      end
    end
  end

  // One request from MEM; expectations come from ref_mem and the cancel schedule only.
  task automatic do_txn(input bit wr, input logic [1:0] size, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int cancel_at, input bit hold, output int lat);
    logic [31:0] exp;
    bit got, cxl;
    int sd0, sd_c;
    exp = ref_mem[addr[4:2]];
    if (wr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr[4:2]][8*b +: 8] = wdata[8*b +: 8];
    data_req = 1'b1; data_wr = wr; data_size = size; data_wstrb = strb;
    data_addr = addr; data_wdata = wdata; cancel = 1'b0;
    @(negedge clk);
    chk("addr_ok_idle", data_addr_ok, 1);
    chk("ok_single_pulse", data_ok, 0);
    @(posedge clk); #1;
    if (!hold) data_req = 1'b0;
    got = 0; cxl = 0; sd0 = slave_done; sd_c = -1; lat = 0;
    for (int c = 1; c <= 80; c++) begin
      cancel = (c == cancel_at);
      if (cancel) cxl = 1;
      @(negedge clk);
      chk("addr_ok_busy", data_addr_ok, 0);
      if (data_ok === 1'b1) begin
        chk("ok_after_cancel", cxl, 0);
        if (!wr) chk("load_rdata", data_rdata, exp);
        else     chk("rdata_hold_store", data_rdata, last_r);
        got = 1; lat = c;
      end
      if (cxl && sd_c < 0 && slave_done != sd0) sd_c = c;
      @(posedge clk); #1;
      if (got || (sd_c >= 0 && c >= sd_c + 1)) break;
    end
    cancel = 1'b0;
    data_req = 1'b0;
    chk("txn_completed", (got || sd_c >= 0), 1);
    if (got && !wr) begin
      chk("ar_addr", last_ar_addr, addr);
      chk("ar_size", last_ar_size, {1'b0, size});
    end
    if (got && wr) begin
      chk("aw_addr", last_aw_addr, addr);
      chk("aw_size", last_aw_size, {1'b0, size});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_ok"}, data_ok, 0);
    chk({tag, "_addr_ok"}, data_addr_ok, 0);
    chk({tag, "_rdata"}, data_rdata, 0);
    chk({tag, "_ar_valid"}, ar_valid, 0);
    chk({tag, "_r_ready"}, r_ready, 0);
    chk({tag, "_aw_valid"}, aw_valid, 0);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_b_ready"}, b_ready, 0);
    chk({tag, "_aw_addr"}, aw_addr, 0);
    chk({tag, "_w_data"}, w_data, 0);
    chk({tag, "_w_strb"}, w_strb, 0);
  endtask

  initial begin : main
    int lat;
    int idx, k;
    bit wr, hold;
    logic [1:0] sz;
    for (int i = 0; i < 8; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Load word, bus immediately ready.
    d_ar = 0; d_r = 0; d_aw = 0; d_w = 0; d_b = 0;
    do_txn(0, 2'd2, 4'h0, 32'h1FC0_0010, 32'h0, 0, 0, lat);
    chk("load_latency", lat, 3);

    // Store byte, aw_ready 3 cycles ahead of w_ready.
    d_w = 3;
    do_txn(1, 2'd0, 4'b0100, 32'hBFAF_F000, 32'h00AB_0000, 0, 0, lat);
    chk("store_split_latency", lat, 6);
    d_w = 0;
    do_txn(1, 2'd0, 4'b0100, 32'hBFAF_F000, 32'h00CD_0000, 0, 0, lat);
    chk("store_joint_latency", lat, 3);
    do_txn(0, 2'd2, 4'h0, 32'hBFAF_F000, 32'h0, 0, 0, lat);

    // Cancel while in R with r_valid 5 cycles late, then a normal load.
    d_r = 5;
    do_txn(0, 2'd2, 4'h0, 32'h1FC0_0008, 32'h0, 3, 0, lat);
    d_r = 0;
    do_txn(0, 2'd1, 4'h0, 32'h1FC0_0004, 32'h0, 0, 0, lat);

    // Cancel in IDLE blocks acceptance.
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1FC0_0000; cancel = 1'b1;
    @(negedge clk);
    chk("cancel_idle_addr_ok", data_addr_ok, 0);
    @(posedge clk); #1;
    data_req = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle_no_ar", ar_valid, 0);
    @(posedge clk); #1;

    // Randomized traffic: random delays, cancels, held requests, back-to-back.
    d_ar = -1; d_r = -1; d_aw = -1; d_w = -1; d_b = -1;
    for (int n = 0; n < 40; n++) begin
      wr   = $urandom_range(0, 1);
      idx  = $urandom_range(0, 7);
      sz   = 2'($urandom_range(0, 2));
      k    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      hold = (k == 0) && $urandom_range(0, 1);
      do_txn(wr, sz, 4'($urandom), 32'hA000_0000 | 32'(idx << 2), $urandom, k, hold, lat);
    end

    // Asynchronous reset during WRITE after aw accepted; w never ready.
    d_aw = 0; d_w = 1000;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'hA000_0000; data_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst_txn_addr_ok", data_addr_ok, 1);
    @(posedge clk); #1;
    data_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_txn_aw_done", aw_valid, 0);
    chk("rst_txn_w_pending", w_valid, 1);
    #2;
    abort = 1;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    last_r = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort = 0;
    d_aw = -1; d_w = -1;
    chk("post_rst_aw_valid", aw_valid, 0);
    do_txn(0, 2'd2, 4'h0, 32'hA000_0000, 32'h0, 0, 0, lat);
    do_txn(1, 2'd2, 4'h3, 32'hA000_0000, 32'hCAFE_F00D, 0, 0, lat);
    do_txn(0, 2'd2, 4'h0, 32'hA000_0000, 32'h0, 0, 0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
